// File: rtl/ird_prefetch_dram_if.sv
// Bus bundle between the instruction-fetch sequencer and the IR prefetch /
// dispatch-RAM block. The master drives fills, IR loads and diag cycles.
interface ird_prefetch_dram_if #(
    parameter int WORD_W = 36,
    parameter int J_W    = 10
);
    localparam int E = 3 + 3 + J_W + 1;

    logic              fill_valid_h;
    logic [WORD_W-1:0] fill_word_h;
    logic              fill_ready_h;
    logic              load_ir_h;
    logic              flush_h;
    logic              ir_valid_h;
    logic [8:0]        ir_op_h;
    logic [3:0]        ir_ac_h;
    logic              ir_acEq0_h;
    logic              dram_valid_h;
    logic [2:0]        dram_a_h;
    logic [2:0]        dram_b_h;
    logic [J_W-1:0]    dram_j_h;
    logic              dram_odd_parity_h;
    logic              parity_err_h;
    logic              diag_wr_h;
    logic              diag_rd_h;
    logic [8:0]        diag_addr_h;
    logic [E-1:0]      diag_wdata_h;
    logic [E-1:0]      diag_rdata_h;
    logic              diag_rvalid_h;

    modport master (
        output fill_valid_h, fill_word_h, load_ir_h, flush_h,
               diag_wr_h, diag_rd_h, diag_addr_h, diag_wdata_h,
        input  fill_ready_h, ir_valid_h, ir_op_h, ir_ac_h, ir_acEq0_h,
               dram_valid_h, dram_a_h, dram_b_h, dram_j_h, dram_odd_parity_h,
               parity_err_h, diag_rdata_h, diag_rvalid_h
    );

    modport slave (
        input  fill_valid_h, fill_word_h, load_ir_h, flush_h,
               diag_wr_h, diag_rd_h, diag_addr_h, diag_wdata_h,
        output fill_ready_h, ir_valid_h, ir_op_h, ir_ac_h, ir_acEq0_h,
               dram_valid_h, dram_a_h, dram_b_h, dram_j_h, dram_odd_parity_h,
               parity_err_h, diag_rdata_h, diag_rvalid_h
    );
endinterface

// File: rtl/ird_prefetch_dram.sv
// Instruction prefetch FIFO feeding the IR, followed by a registered dispatch
// RAM (DRAM) lookup on the IR opcode, with a diagnostic read/write port.
module ird_prefetch_dram #(
    parameter int WORD_W = 36,
    parameter int DEPTH  = 4,
    parameter int J_W    = 10
) (
    input  logic               clk_h,
    input  logic               reset_l,
    ird_prefetch_dram_if.slave bus
);
    localparam int E     = 3 + 3 + J_W + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IR_W  = 13;

    function automatic logic odd_parity(input logic [E-1:0] entry);
        return ^entry;
    endfunction

    logic [IR_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fill_ready;
    logic             push;
    logic             pop;
    logic             unused_fill_low;

    assign fill_ready = (count < CNT_W'(DEPTH));
    assign push       = bus.fill_valid_h & fill_ready;
    assign pop        = bus.load_ir_h & (count != '0);
    // Only opcode and AC (bits 0-12) are decoded here; the rest of the word goes elsewhere.
    assign unused_fill_low = ^bus.fill_word_h;

    always_ff @(posedge clk_h) begin
        if (push) fifo_mem[wr_ptr] <= bus.fill_word_h[WORD_W-1 -: IR_W];
    end

    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush_h) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Stage p1: instruction register
    logic [IR_W-1:0] ir_p1;
    logic            vld_p1;

    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            ir_p1  <= '0;
            vld_p1 <= 1'b0;
        end else if (bus.flush_h) begin
            vld_p1 <= 1'b0;
        end else if (bus.load_ir_h) begin
            vld_p1 <= pop;
            if (pop) ir_p1 <= fifo_mem[rd_ptr];
        end
    end

    // Stage p2: dispatch RAM lookup on the IR opcode, plus diag read port
    logic [E-1:0] dram_mem [512];
    logic [E-1:0] dram_p2;
    logic         vld_p2;
    logic         err_p3;
    logic         parity_fault;
    logic [E-1:0] diag_rdata_p1;
    logic         diag_rvld_p1;

    always_ff @(posedge clk_h) begin
        if (bus.diag_wr_h) dram_mem[bus.diag_addr_h] <= bus.diag_wdata_h;
    end

    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            dram_p2       <= '0;
            vld_p2        <= 1'b0;
            err_p3        <= 1'b0;
            diag_rdata_p1 <= '0;
            diag_rvld_p1  <= 1'b0;
        end else begin
            dram_p2      <= dram_mem[ir_p1[IR_W-1 -: 9]];
            // A new IR (or a flush) invalidates the lookup for one cycle.
            vld_p2       <= vld_p1 & ~bus.flush_h & ~bus.load_ir_h;
            err_p3       <= err_p3 | parity_fault;
            diag_rvld_p1 <= bus.diag_rd_h;
            if (bus.diag_rd_h) diag_rdata_p1 <= dram_mem[bus.diag_addr_h];
        end
    end

    assign parity_fault = vld_p2 & ~odd_parity(dram_p2);

    assign bus.fill_ready_h      = fill_ready;
    assign bus.ir_valid_h        = vld_p1;
    assign bus.ir_op_h           = ir_p1[IR_W-1 -: 9];
    assign bus.ir_ac_h           = ir_p1[3:0];
    assign bus.ir_acEq0_h        = (ir_p1[3:0] == 4'd0);
    assign bus.dram_valid_h      = vld_p2;
    assign bus.dram_a_h          = dram_p2[E-1 -: 3];
    assign bus.dram_b_h          = dram_p2[E-4 -: 3];
    assign bus.dram_j_h          = dram_p2[J_W:1];
    assign bus.dram_odd_parity_h = odd_parity(dram_p2);
    assign bus.parity_err_h      = err_p3 | parity_fault;
    assign bus.diag_rdata_h      = diag_rdata_p1;
    assign bus.diag_rvalid_h     = diag_rvld_p1;
endmodule

// File: tb/tb_ird_prefetch_dram.sv
// Randomized bench for ird_prefetch_dram against a queue-based reference model.
module tb_ird_prefetch_dram;
    localparam int WORD_W = 36;
    localparam int DEPTH  = 4;
    localparam int J_W    = 10;
    localparam int E      = 3 + 3 + J_W + 1;

    logic clk_h   = 1'b0;
    logic reset_l = 1'b1;
    always #5 clk_h = ~clk_h;

    ird_prefetch_dram_if #(.WORD_W(WORD_W), .J_W(J_W)) bus ();

    ird_prefetch_dram #(.WORD_W(WORD_W), .DEPTH(DEPTH), .J_W(J_W)) dut (
        .clk_h   (clk_h),
        .reset_l (reset_l),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [WORD_W-1:0] m_q [$];
    logic [8:0]        m_op;
    logic [3:0]        m_ac;
    bit                m_iv;
    logic [E-1:0]      m_mem [512];
    logic [E-1:0]      m_dq;
    bit                m_dv;
    bit                m_err;
    logic [E-1:0]      m_rdata;
    bit                m_rvalid;
    bit                mem_ready = 1'b0;

    function automatic bit odd_of(input logic [E-1:0] e);
        return ($countones(e) % 2) == 1;
    endfunction

    function automatic logic [E-1:0] make_entry(input bit want_odd);
        logic [E-1:0] e;
        e = E'($urandom());
        if (odd_of(e) != want_odd) e[0] = ~e[0];
        return e;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_op = '0; m_ac = '0; m_iv = 1'b0;
        m_dq = '0; m_dv = 1'b0; m_err = 1'b0;
        m_rdata = '0; m_rvalid = 1'b0;
    endtask

    task automatic model_step();
        logic [E-1:0]      n_dq;
        bit                n_dv;
        bit                can_push;
        logic [WORD_W-1:0] w;
        n_dq  = m_mem[m_op];
        n_dv  = m_iv && !bus.flush_h && !bus.load_ir_h;
        m_err = m_err | (m_dv && !odd_of(m_dq));
        if (bus.diag_rd_h) m_rdata = m_mem[bus.diag_addr_h];
        m_rvalid = bus.diag_rd_h;
        if (bus.diag_wr_h) m_mem[bus.diag_addr_h] = bus.diag_wdata_h;
        if (bus.flush_h) begin
            m_q.delete();
            m_iv = 1'b0;
        end else begin
            can_push = m_q.size() < DEPTH;
            if (bus.load_ir_h) begin
                if (m_q.size() > 0) begin
                    w    = m_q.pop_front();
                    m_op = w[35:27];
                    m_ac = w[26:23];
                    m_iv = 1'b1;
                end else begin
                    m_iv = 1'b0;
                end
            end
            if (bus.fill_valid_h && can_push) m_q.push_back(bus.fill_word_h);
        end
        m_dq = n_dq;
        m_dv = n_dv;
    endtask

    task automatic check_outputs();
        check_eq("fill_ready", 64'(bus.fill_ready_h), 64'(m_q.size() < DEPTH));
        check_eq("ir_valid", 64'(bus.ir_valid_h), 64'(m_iv));
        check_eq("ir_op", 64'(bus.ir_op_h), 64'(m_op));
        check_eq("ir_ac", 64'(bus.ir_ac_h), 64'(m_ac));
        check_eq("ir_acEq0", 64'(bus.ir_acEq0_h), 64'(m_ac == 4'd0));
        check_eq("dram_valid", 64'(bus.dram_valid_h), 64'(m_dv));
        check_eq("parity_err", 64'(bus.parity_err_h), 64'(m_err | (m_dv & !odd_of(m_dq))));
        check_eq("diag_rvalid", 64'(bus.diag_rvalid_h), 64'(m_rvalid));
        if (m_rvalid) check_eq("diag_rdata", 64'(bus.diag_rdata_h), 64'(m_rdata));
        if (mem_ready) begin
            check_eq("dram_a", 64'(bus.dram_a_h), 64'(m_dq[E-1 -: 3]));
            check_eq("dram_b", 64'(bus.dram_b_h), 64'(m_dq[E-4 -: 3]));
            check_eq("dram_j", 64'(bus.dram_j_h), 64'(m_dq[J_W:1]));
            check_eq("dram_odd", 64'(bus.dram_odd_parity_h), 64'(odd_of(m_dq)));
        end
    endtask

    task automatic check_reset_state();
        check_eq("rst_fill_ready", 64'(bus.fill_ready_h), 64'd1);
        check_eq("rst_acEq0", 64'(bus.ir_acEq0_h), 64'd1);
        check_eq("rst_ir_valid", 64'(bus.ir_valid_h), 64'd0);
        check_eq("rst_ir_op", 64'(bus.ir_op_h), 64'd0);
        check_eq("rst_ir_ac", 64'(bus.ir_ac_h), 64'd0);
        check_eq("rst_dram_valid", 64'(bus.dram_valid_h), 64'd0);
        check_eq("rst_dram_abj", 64'({bus.dram_a_h, bus.dram_b_h, bus.dram_j_h}), 64'd0);
        check_eq("rst_dram_odd", 64'(bus.dram_odd_parity_h), 64'd0);
        check_eq("rst_parity_err", 64'(bus.parity_err_h), 64'd0);
        check_eq("rst_rvalid", 64'(bus.diag_rvalid_h), 64'd0);
        check_eq("rst_rdata", 64'(bus.diag_rdata_h), 64'd0);
    endtask

    task automatic drive_idle();
        bus.fill_valid_h = 1'b0;
        bus.fill_word_h  = '0;
        bus.load_ir_h    = 1'b0;
        bus.flush_h      = 1'b0;
        bus.diag_wr_h    = 1'b0;
        bus.diag_rd_h    = 1'b0;
        bus.diag_addr_h  = '0;
        bus.diag_wdata_h = '0;
    endtask

    task automatic drive_random(input bit allow_even);
        bus.fill_valid_h = ($urandom_range(0, 99) < 55);
        bus.fill_word_h  = WORD_W'({$urandom(), $urandom()});
        bus.load_ir_h    = ($urandom_range(0, 99) < 35);
        bus.flush_h      = ($urandom_range(0, 99) < 3);
        bus.diag_wr_h    = ($urandom_range(0, 99) < 6);
        bus.diag_rd_h    = ($urandom_range(0, 99) < 20);
        bus.diag_addr_h  = ($urandom_range(0, 3) == 0) ? m_op : 9'($urandom());
        bus.diag_wdata_h = allow_even ? E'($urandom()) : make_entry(1'b1);
    endtask

    // One clock: check outputs mid-cycle, advance model on the edge, return 1 time unit later.
    task automatic cycle();
        @(negedge clk_h);
        check_outputs();
        @(posedge clk_h);
        if (reset_l) model_step();
        #1;
    endtask

    logic [8:0]   saved_op;
    logic [E-1:0] old_entry;
    logic [E-1:0] new_entry;

    initial begin
        drive_idle();
        model_reset();
        #2 reset_l = 1'b0;
        #1 check_reset_state();
        @(posedge clk_h); @(posedge clk_h);
        #1 reset_l = 1'b1;

        // Software initialisation of the whole DRAM with odd-parity entries.
        for (int a = 0; a < 512; a++) begin
            bus.diag_wr_h    = 1'b1;
            bus.diag_addr_h  = 9'(a);
            bus.diag_wdata_h = make_entry(1'b1);
            cycle();
        end
        drive_idle();
        cycle();
        mem_ready = 1'b1;

        // Basic dispatch of opcode 0o200.
        bus.diag_wr_h = 1'b1; bus.diag_addr_h = 9'o200;
        bus.diag_wdata_h = {3'd1, 3'd2, 10'o123, 1'b1};
        cycle();
        drive_idle();
        bus.fill_valid_h = 1'b1; bus.fill_word_h = 36'o200040000000;
        cycle();
        drive_idle();
        bus.load_ir_h = 1'b1;
        cycle();
        check_eq("ld_ir_op", 64'(bus.ir_op_h), 64'(9'o200));
        check_eq("ld_ir_ac", 64'(bus.ir_ac_h), 64'd1);
        check_eq("ld_acEq0", 64'(bus.ir_acEq0_h), 64'd0);
        check_eq("ld_ir_valid", 64'(bus.ir_valid_h), 64'd1);
        check_eq("ld_dvalid_n1", 64'(bus.dram_valid_h), 64'd0);
        drive_idle();
        cycle();
        check_eq("ld_dvalid_n2", 64'(bus.dram_valid_h), 64'd1);
        check_eq("ld_dram_a", 64'(bus.dram_a_h), 64'd1);
        check_eq("ld_dram_b", 64'(bus.dram_b_h), 64'd2);
        check_eq("ld_dram_j", 64'(bus.dram_j_h), 64'(10'o123));
        check_eq("ld_dram_odd", 64'(bus.dram_odd_parity_h), 64'd1);

        // Fill to DEPTH, then simultaneous push/pop across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            bus.fill_valid_h = 1'b1; bus.fill_word_h = WORD_W'({$urandom(), $urandom()});
            cycle();
        end
        check_eq("full_ready", 64'(bus.fill_ready_h), 64'd0);
        bus.fill_word_h = WORD_W'({$urandom(), $urandom()});
        cycle();
        drive_idle();
        bus.load_ir_h = 1'b1;
        cycle();
        check_eq("cnt3_ready", 64'(bus.fill_ready_h), 64'd1);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            bus.load_ir_h = 1'b1; bus.fill_valid_h = 1'b1;
            bus.fill_word_h = WORD_W'({$urandom(), $urandom()});
            cycle();
            check_eq("pushpop_ready", 64'(bus.fill_ready_h), 64'd1);
        end
        drive_idle();
        bus.load_ir_h = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        drive_idle();
        cycle();

        // Flush overriding a same-cycle push and pop at count 2.
        for (int i = 0; i < 2; i++) begin
            bus.fill_valid_h = 1'b1; bus.fill_word_h = WORD_W'({$urandom(), $urandom()});
            cycle();
        end
        saved_op = m_op;
        bus.fill_valid_h = 1'b1; bus.load_ir_h = 1'b1; bus.flush_h = 1'b1;
        cycle();
        check_eq("flush_ir_valid", 64'(bus.ir_valid_h), 64'd0);
        check_eq("flush_dvalid", 64'(bus.dram_valid_h), 64'd0);
        check_eq("flush_ready", 64'(bus.fill_ready_h), 64'd1);
        check_eq("flush_ir_op", 64'(bus.ir_op_h), 64'(saved_op));
        drive_idle();
        bus.load_ir_h = 1'b1;
        cycle();
        check_eq("flush_empty", 64'(bus.ir_valid_h), 64'd0);
        drive_idle();

        // Diag read-before-write on the same address.
        old_entry = m_mem[5];
        new_entry = ~old_entry;
        bus.diag_wr_h = 1'b1; bus.diag_rd_h = 1'b1; bus.diag_addr_h = 9'd5;
        bus.diag_wdata_h = new_entry;
        cycle();
        check_eq("rbw_rvalid", 64'(bus.diag_rvalid_h), 64'd1);
        check_eq("rbw_old", 64'(bus.diag_rdata_h), 64'(old_entry));
        bus.diag_wr_h = 1'b0;
        cycle();
        check_eq("rbw_new", 64'(bus.diag_rdata_h), 64'(new_entry));
        drive_idle();
        cycle();
        check_eq("rvalid_pulse", 64'(bus.diag_rvalid_h), 64'd0);

        // Random traffic, odd-parity writes only.
        for (int i = 0; i < 1500; i++) begin
            drive_random(1'b0);
            cycle();
        end
        drive_idle();

        // Even-parity entry makes the error sticky.
        bus.flush_h = 1'b1;
        cycle();
        bus.flush_h = 1'b0;
        bus.diag_wr_h = 1'b1; bus.diag_addr_h = 9'o300;
        bus.diag_wdata_h = {3'd1, 3'd1, 10'd0, 1'b0};
        cycle();
        drive_idle();
        bus.fill_valid_h = 1'b1; bus.fill_word_h = 36'o300000000000;
        cycle();
        drive_idle();
        bus.load_ir_h = 1'b1;
        cycle();
        check_eq("perr_n1", 64'(bus.parity_err_h), 64'd0);
        drive_idle();
        cycle();
        check_eq("perr_n2", 64'(bus.parity_err_h), 64'd1);
        bus.flush_h = 1'b1;
        cycle();
        drive_idle();
        cycle();
        check_eq("perr_flush", 64'(bus.parity_err_h), 64'd1);

        // Random traffic, any parity.
        for (int i = 0; i < 1000; i++) begin
            drive_random(1'b1);
            cycle();
        end

        // Asynchronous reset mid-operation; DRAM must survive.
        drive_random(1'b1);
        @(negedge clk_h);
        check_outputs();
        #2;
        drive_idle();
        reset_l = 1'b0;
        #1;
        model_reset();
        check_reset_state();
        cycle();
        cycle();
        reset_l = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.diag_rd_h = 1'b1; bus.diag_addr_h = 9'($urandom());
            cycle();
        end
        drive_idle();
        for (int i = 0; i < 300; i++) begin
            drive_random(1'b1);
            cycle();
        end
        drive_idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ird_prefetch_dram.md
IRD_PREFETCH_DRAM -- requirements
Module: ird_prefetch_dram
Interface
REQ-001 SHALL have parameter WORD_W, default 36, instruction word width in bits, minimum 13; bit numbering is MSB = PDP-10 bit 0.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries, a power of 2 and at least 2.
REQ-003 SHALL have parameter J_W, default 10, DRAM J-field width; DRAM entry width E = 3+3+J_W+1 (A, B, J, parity).
REQ-004 SHALL have port clk_h  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_l  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port fill_valid_h  in  1  fill_word_h is offered to the queue.
REQ-007 SHALL have port fill_word_h  in  WORD_W  instruction word from the memory buffer.
REQ-008 SHALL have port fill_ready_h  out  1  queue can accept a word (count < DEPTH).
REQ-009 SHALL have port load_ir_h  in  1  pop the queue head into IR.
REQ-010 SHALL have port flush_h  in  1  discard queue, IR-valid and DRAM-valid.
REQ-011 SHALL have port ir_valid_h  out  1  IR holds a live instruction.
REQ-012 SHALL have port ir_op_h  out  9  IR opcode, bits 0-8.
REQ-013 SHALL have port ir_ac_h  out  4  IR AC field, bits 9-12.
REQ-014 SHALL have port ir_acEq0_h  out  1  ir_ac_h == 0.
REQ-015 SHALL have port dram_valid_h  out  1  dram_* outputs match the current IR opcode.
REQ-016 SHALL have port dram_a_h  out  3  DRAM A field.
REQ-017 SHALL have port dram_b_h  out  3  DRAM B field.
REQ-018 SHALL have port dram_j_h  out  J_W  DRAM J field.
REQ-019 SHALL have port dram_odd_parity_h  out  1  XOR of all E bits of the looked-up entry.
REQ-020 SHALL have port parity_err_h  out  1  sticky DRAM parity error.
REQ-021 SHALL have port diag_wr_h  in  1  write diag_wdata_h into DRAM at diag_addr_h.
REQ-022 SHALL have port diag_rd_h  in  1  read DRAM at diag_addr_h.
REQ-023 SHALL have port diag_addr_h  in  9  DRAM diagnostic address.
REQ-024 SHALL have port diag_wdata_h  in  E  entry to write, {A,B,J,P} MSB first.
REQ-025 SHALL have port diag_rdata_h  out  E  diagnostic read data.
REQ-026 SHALL have port diag_rvalid_h  out  1  one-cycle pulse, diag_rdata_h valid.
Function
REQ-027 Queue SHALL be a DEPTH-entry FIFO; a push occurs when fill_valid_h & fill_ready_h, a pop when load_ir_h & count>0; push and pop in one cycle leave count unchanged.
REQ-028 fill_ready_h SHALL derive from registered count only; no push accepted at count==DEPTH; read/write pointers wrap modulo DEPTH.
REQ-029 Pop in cycle N SHALL load the head word into IR at edge N+1 and set ir_valid_h; load_ir_h with empty queue SHALL clear ir_valid_h and dram_valid_h, leave IR fields unchanged.
REQ-030 DRAM (512 x E, registered read) SHALL be indexed by ir_op_h; dram_* fields and dram_valid_h SHALL update one cycle after IR load (edge N+2); dram_valid_h=0 at edge N+1.
REQ-031 parity_err_h SHALL set on any cycle with dram_valid_h=1 and dram_odd_parity_h=0; it clears only on reset.
REQ-032 diag_wr_h SHALL write in one cycle; a same-cycle lookup or diag read of that address SHALL return the old entry (read-before-write).
REQ-033 diag_rd_h in cycle N SHALL drive diag_rdata_h and pulse diag_rvalid_h in cycle N+1; the read port is independent of the lookup port.
REQ-034 flush_h SHALL zero count and pointers and clear ir_valid_h and dram_valid_h at the next edge; it overrides a same-cycle push and pop (word dropped, IR unchanged).
REQ-035 DRAM contents SHALL NOT be reset; software initialises them via diag writes.
Reset
REQ-036 reset_l low SHALL immediately force count=0, pointers=0, IR=0, all outputs 0 except fill_ready_h=1 and ir_acEq0_h=1; deassertion mid-operation leaves DRAM intact.
Verification
REQ-037 Diag-write op 0o200 with {A=1,B=2,J=0o123,P odd}, push 0o200_040_000_000, pulse load_ir -> ir_op=0o200, ir_ac=1, ir_acEq0=0 at N+1; dram A=1,B=2,J=0o123, odd_parity=1, valid at N+2.
REQ-038 Push DEPTH words with load_ir low -> fill_ready=0 after 4th; push+pop same cycle at count 3 -> count stays 3, FIFO order preserved across pointer wrap.
REQ-039 Write entry with even ones count, load that opcode -> parity_err_h=1 from N+2, remains 1 after flush, clears only on reset_l low.
REQ-040 flush_h together with fill_valid and load_ir at count 2 -> count 0, ir_valid=0, dram_valid=0, IR fields unchanged.
REQ-041 diag_wr and diag_rd same address same cycle -> diag_rvalid next cycle with old data; read again -> new data.
